// File: rtl/regfile_param.sv
// Purpose : parametrised register file with two read ports, one write port, condition bit and busy scoreboard.
// Latency : reads are combinational; writes, CB and scoreboard updates take effect on the next rising clk_i edge.
// Backpressure: none; every write, busy set and CB write is accepted in the cycle it is presented.
//
// Ports:
//   clk_i, reset_i             clock and synchronous active-high reset
//   write_i / write_addr_i /
//   write_data_i               register write port (also clears the busy bit of write_addr_i)
//   write_CB_i / cb_data_i     condition-bit write
//   rs_addr_i / rt_addr_i      read addresses
//   busy_set_i / busy_addr_i   mark a register as awaiting writeback
//   rs_data_o / rt_data_o      read data
//   cb_data_o                  condition bit
//   rs_busy_o / rt_busy_o      scoreboard bits for the read addresses
module regfile_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] write_addr_i,
    input  logic [DATA_W-1:0] write_data_i,
    input  logic              write_CB_i,
    input  logic              cb_data_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic              busy_set_i,
    input  logic [ADDR_W-1:0] busy_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic              cb_data_o,
    output logic              rs_busy_o,
    output logic              rt_busy_o
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                cb;

    logic wr_en;
    logic set_en;
    logic rs_zero;
    logic rt_zero;

    // Register 0 is read-only and never pending when it is hardwired.
    assign wr_en   = write_i    && !((ZERO_REG != 0) && (write_addr_i == '0));
    assign set_en  = busy_set_i && !((ZERO_REG != 0) && (busy_addr_i  == '0));
    assign rs_zero = (ZERO_REG != 0) && (rs_addr_i == '0);
    assign rt_zero = (ZERO_REG != 0) && (rt_addr_i == '0);

    // Clear is applied first so a same-address set overrides it: the set
    // means a newer producer has been issued for that register.
    always_comb begin
        busy_next = busy;
        if (write_i) begin
            busy_next[write_addr_i] = 1'b0;
        end
        if (set_en) begin
            busy_next[busy_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
            cb   <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[write_addr_i] <= write_data_i;
            end
            if (write_CB_i) begin
                cb <= cb_data_i;
            end
            busy <= busy_next;
        end
    end

    // Read ports: stored value, optionally overridden by the in-flight
    // write, and finally forced to zero for a hardwired register 0.
    always_comb begin
        rs_data_o = regs[rs_addr_i];
        if ((BYPASS != 0) && write_i && (write_addr_i == rs_addr_i)) begin
            rs_data_o = write_data_i;
        end
        if (rs_zero) begin
            rs_data_o = '0;
        end
    end

    always_comb begin
        rt_data_o = regs[rt_addr_i];
        if ((BYPASS != 0) && write_i && (write_addr_i == rt_addr_i)) begin
            rt_data_o = write_data_i;
        end
        if (rt_zero) begin
            rt_data_o = '0;
        end
    end

    assign cb_data_o = ((BYPASS != 0) && write_CB_i) ? cb_data_i : cb;

    // Busy outputs reflect stored state only; a set or clear in flight is
    // not forwarded.
    assign rs_busy_o = busy[rs_addr_i] && !rs_zero;
    assign rt_busy_o = busy[rt_addr_i] && !rt_zero;

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus; 8-bit instances see the low slices.
    logic        rst;
    logic        wr;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        wcb;
    logic        cbd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic        bset;
    logic [3:0]  baddr;

    logic [7:0]  rsd8 [4];
    logic [7:0]  rtd8 [4];
    logic [15:0] rsd16;
    logic [15:0] rtd16;
    logic        cbo [5];
    logic        rsb [5];
    logic        rtb [5];

    // Instance configurations: 0..3 are 8x8 variants, 4 is 16-bit x 16.
    localparam int P_AW [5] = '{3, 3, 3, 3, 4};
    localparam int P_DW [5] = '{8, 8, 8, 8, 16};
    localparam int P_BY [5] = '{1, 0, 1, 0, 1};
    localparam int P_ZR [5] = '{0, 0, 1, 1, 0};

    for (genvar g = 0; g < 4; g++) begin : g8
        regfile_param #(
            .DATA_W  (8),
            .ADDR_W  (3),
            .BYPASS  ((g % 2 == 0) ? 1 : 0),
            .ZERO_REG((g >= 2) ? 1 : 0)
        ) u_dut (
            .clk_i       (clk),
            .reset_i     (rst),
            .write_i     (wr),
            .write_addr_i(waddr[2:0]),
            .write_data_i(wdata[7:0]),
            .write_CB_i  (wcb),
            .cb_data_i   (cbd),
            .rs_addr_i   (rs[2:0]),
            .rt_addr_i   (rt[2:0]),
            .busy_set_i  (bset),
            .busy_addr_i (baddr[2:0]),
            .rs_data_o   (rsd8[g]),
            .rt_data_o   (rtd8[g]),
            .cb_data_o   (cbo[g]),
            .rs_busy_o   (rsb[g]),
            .rt_busy_o   (rtb[g])
        );
    end

    regfile_param #(
        .DATA_W  (16),
        .ADDR_W  (4),
        .BYPASS  (1),
        .ZERO_REG(0)
    ) u_dut16 (
        .clk_i       (clk),
        .reset_i     (rst),
        .write_i     (wr),
        .write_addr_i(waddr),
        .write_data_i(wdata),
        .write_CB_i  (wcb),
        .cb_data_i   (cbd),
        .rs_addr_i   (rs),
        .rt_addr_i   (rt),
        .busy_set_i  (bset),
        .busy_addr_i (baddr),
        .rs_data_o   (rsd16),
        .rt_data_o   (rtd16),
        .cb_data_o   (cbo[4]),
        .rs_busy_o   (rsb[4]),
        .rt_busy_o   (rtb[4])
    );

    // Reference model: plain arrays per instance.
    logic [15:0] m_reg  [5][16];
    logic        m_busy [5][16];
    logic        m_cb   [5];

    int total = 0;
    int bad   = 0;

    function automatic logic [3:0] amask(int i);
        return (P_AW[i] == 4) ? 4'hF : 4'h7;
    endfunction

    function automatic logic [15:0] dmask(int i);
        return (P_DW[i] == 16) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic logic [15:0] exp_rd(int i, logic [3:0] a_in);
        logic [3:0] a;
        logic [3:0] wa;
        a  = a_in & amask(i);
        wa = waddr & amask(i);
        if (P_ZR[i] != 0 && a == 4'd0) return 16'h0;
        if (P_BY[i] != 0 && wr && wa == a) return wdata & dmask(i);
        return m_reg[i][a];
    endfunction

    function automatic logic exp_busy(int i, logic [3:0] a_in);
        logic [3:0] a;
        a = a_in & amask(i);
        if (P_ZR[i] != 0 && a == 4'd0) return 1'b0;
        return m_busy[i][a];
    endfunction

    function automatic logic exp_cb(int i);
        if (P_BY[i] != 0 && wcb) return cbd;
        return m_cb[i];
    endfunction

    task automatic chk(string tag, int i, logic [15:0] obs, logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s inst%0d observed=%h expected=%h", tag, i, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [15:0] ors;
        logic [15:0] ort;
        for (int i = 0; i < 5; i++) begin
            ors = (i < 4) ? {8'h00, rsd8[i]} : rsd16;
            ort = (i < 4) ? {8'h00, rtd8[i]} : rtd16;
            chk({tag, "/rs_data"}, i, ors, exp_rd(i, rs));
            chk({tag, "/rt_data"}, i, ort, exp_rd(i, rt));
            chk({tag, "/cb"},      i, {15'h0, cbo[i]}, {15'h0, exp_cb(i)});
            chk({tag, "/rs_busy"}, i, {15'h0, rsb[i]}, {15'h0, exp_busy(i, rs)});
            chk({tag, "/rt_busy"}, i, {15'h0, rtb[i]}, {15'h0, exp_busy(i, rt)});
        end
    endtask

    // Applies the architectural effect of one rising edge to the model.
    task automatic model_edge();
        logic [3:0] wa;
        logic [3:0] ba;
        for (int i = 0; i < 5; i++) begin
            if (rst) begin
                for (int r = 0; r < 16; r++) begin
                    m_reg[i][r]  = 16'h0;
                    m_busy[i][r] = 1'b0;
                end
                m_cb[i] = 1'b0;
            end else begin
                wa = waddr & amask(i);
                ba = baddr & amask(i);
                if (wr && !(P_ZR[i] != 0 && wa == 4'd0)) m_reg[i][wa] = wdata & dmask(i);
                if (wr) m_busy[i][wa] = 1'b0;
                if (bset && !(P_ZR[i] != 0 && ba == 4'd0)) m_busy[i][ba] = 1'b1;
                if (wcb) m_cb[i] = cbd;
            end
        end
    endtask

    task automatic step(string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst  = 1'b0;
        wr   = 1'b0;
        wcb  = 1'b0;
        bset = 1'b0;
    endtask

    initial begin
        idle();
        waddr = 4'd0; wdata = 16'h0; cbd = 1'b0;
        rs = 4'd0; rt = 4'd0; baddr = 4'd0;

        // Reset edge (outputs undefined before it, so not checked).
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        rst = 1'b0;

        // Reset state on every address of both ports.
        for (int a = 0; a < 16; a++) begin
            rs = 4'(a); rt = 4'(15 - a);
            step("reset_read");
        end

        // Write/read latency.
        wr = 1'b1; waddr = 4'd0; wdata = 16'h0011; rt = 4'd0;
        step("wr0_same_cycle");
        idle(); rt = 4'd0;
        step("wr0_readback");
        wr = 1'b1; waddr = 4'd7; wdata = 16'h00A5; rs = 4'd7; rt = 4'd7;
        step("wr7_same_cycle");
        idle();
        step("wr7_readback");

        // Bypass of data and CB.
        wr = 1'b1; waddr = 4'd3; wdata = 16'h005C; rs = 4'd3; rt = 4'd2;
        wcb = 1'b1; cbd = 1'b1;
        step("bypass");
        idle();
        step("bypass_after");

        // Scoreboard set, clear, and same-address set-wins.
        bset = 1'b1; baddr = 4'd2; rs = 4'd2; rt = 4'd4;
        step("busy_set2");
        idle();
        step("busy2_seen");
        wr = 1'b1; waddr = 4'd2; wdata = 16'h0022;
        step("busy2_clear_edge");
        idle();
        step("busy2_cleared");
        bset = 1'b1; baddr = 4'd4; wr = 1'b1; waddr = 4'd4; wdata = 16'h004D;
        rs = 4'd4; rt = 4'd4;
        step("set_clr_same");
        idle();
        step("set_wins");
        bset = 1'b1; baddr = 4'd6; wr = 1'b1; waddr = 4'd4; wdata = 16'h0044;
        rs = 4'd6;
        step("set_clr_diff");
        idle();
        step("set_clr_diff_after");

        // Zero register.
        wr = 1'b1; waddr = 4'd0; wdata = 16'h00FF; bset = 1'b1; baddr = 4'd0;
        rs = 4'd0; rt = 4'd0;
        step("zero_wr");
        idle();
        step("zero_after");

        // Reset overrides a concurrent write and busy set.
        rst = 1'b1; wr = 1'b1; waddr = 4'd1; wdata = 16'h0033;
        bset = 1'b1; baddr = 4'd5; rs = 4'd1; rt = 4'd5;
        step("reset_mid");
        idle();
        step("reset_mid_after");

        // Wide instance top address.
        wr = 1'b1; waddr = 4'd15; wdata = 16'hBEEF; rs = 4'd15; rt = 4'd14;
        step("wide_wr15");
        idle(); rt = 4'd15;
        step("wide_rd15");

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 31) == 0);
            wr    = 1'($urandom_range(0, 1));
            waddr = 4'($urandom);
            wdata = 16'($urandom);
            wcb   = 1'($urandom_range(0, 1));
            cbd   = 1'($urandom_range(0, 1));
            rs    = 4'($urandom);
            rt    = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
            bset  = 1'($urandom_range(0, 1));
            baddr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
            step("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
